// File: rtl/logicap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logicap_pkg
//  Description : Shared types and sizing constants for the logic-capture /
//                pattern-playback blocks.
//                  - state_t    : playback sequencer states
//                  - LC_SIZE    : default sample / output bus width
//                  - LC_MAX_DIV : default maximum clock divide ratio
//                  - LC_SADDR_W : sample-count width shared with capture
//                  - div_w()    : divider-setting width for a given ratio
//  Revision    : 1.0  initial release
// ============================================================================
package logicap_pkg;

   localparam int LC_SIZE    = 32;
   localparam int LC_MAX_DIV = 32;
   localparam int LC_SADDR_W = 24;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // A divide range of 1 still needs a one-bit setting field.
   function automatic int div_w(input int max_div);
      return (max_div > 1) ? $clog2(max_div) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_tick.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_tick
//  Description : Programmable rate divider producing a one-cycle tick every
//                div+1 clocks.
//  Ports       : clk     - clock
//                reset   - asynchronous active-high reset
//                clr     - force counter to zero
//                preset  - load counter with div so the next cycle ticks
//                div     - divide setting (period = div+1 cycles)
//                tick    - high when counter equals div
//  Revision    : 1.0  initial release
// ============================================================================
module clkdiv_tick
   import logicap_pkg::*;
#(
   parameter int DIV_W = div_w(LC_MAX_DIV)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             preset,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] r_cnt;
   logic             w_tick;

   assign w_tick = (r_cnt == div);
   assign tick   = w_tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (preset) begin
         r_cnt <= div;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_player
//  Description : Plays an AXI-Stream of sample words onto a parallel output
//                bus at a programmable divided rate (pattern generator).
//  Ports       : clk, reset          - clock, async active-high reset
//                ckdiv, count        - divide setting / sample count (0 = until
//                                      tlast), latched at start
//                start, abort        - one-cycle control pulses
//                s_tdata/tvalid/tlast/tready - stream slave
//                dout, dstrobe       - registered output bus and update pulse
//                busy, done, underrun- status
//  Revision    : 1.0  initial release
// ============================================================================
module pattern_player
   import logicap_pkg::*;
#(
   parameter  int SIZE    = LC_SIZE,
   parameter  int MAX_DIV = LC_MAX_DIV,
   parameter  int SADDR_W = LC_SADDR_W,
   localparam int DIV_W   = div_w(MAX_DIV)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIV_W-1:0]   ckdiv,
   input  logic               start,
   input  logic               abort,
   input  logic [SADDR_W-1:0] count,
   input  logic [SIZE-1:0]    s_tdata,
   input  logic               s_tvalid,
   input  logic               s_tlast,
   output logic               s_tready,
   output logic [SIZE-1:0]    dout,
   output logic               dstrobe,
   output logic               busy,
   output logic               done,
   output logic               underrun
);

   state_t             r_state;
   state_t             w_next;

   logic [DIV_W-1:0]   r_ckdiv;
   logic [SADDR_W-1:0] r_count;
   logic [SADDR_W-1:0] r_emit;
   logic [SIZE-1:0]    r_hold_data;
   logic               r_hold_last;
   logic               r_hold_vld;
   logic [SIZE-1:0]    r_dout;
   logic               r_dstrobe;
   logic               r_done;
   logic               r_underrun;

   logic               w_start_ok;
   logic               w_active;
   logic               w_tick;
   logic               w_tick_run;
   logic               w_emit;
   logic               w_finish;
   logic               w_hs;
   logic               w_enter_run;
   logic [SADDR_W-1:0] w_emit_inc;

   assign w_start_ok = start && !abort && (r_state == S_IDLE);
   assign w_active   = (r_state == S_PRIME) || (r_state == S_RUN);

   // Abort suppresses the tick so the pending hold word is never emitted.
   assign w_tick_run = (r_state == S_RUN) && w_tick && !abort;
   assign w_emit     = w_tick_run && r_hold_vld;
   assign w_emit_inc = r_emit + SADDR_W'(1);
   assign w_finish   = w_emit &&
                       (r_hold_last || ((r_count != '0) && (w_emit_inc == r_count)));

   // Refill on consume is withheld when the consumed word is the final one,
   // so a word belonging to the next pattern stays in the upstream FIFO.
   assign s_tready = w_active && !abort && (!r_hold_vld || (w_emit && !w_finish));
   assign w_hs     = s_tvalid && s_tready;

   assign w_enter_run = (r_state == S_PRIME) && (w_next == S_RUN);

   clkdiv_tick #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk    (clk),
      .reset  (reset),
      .clr    (w_start_ok),
      .preset (w_enter_run),
      .div    (r_ckdiv),
      .tick   (w_tick)
   );

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next = S_PRIME;
         end
         S_PRIME: begin
            if (abort)                   w_next = S_IDLE;
            else if (w_hs || r_hold_vld) w_next = S_RUN;
         end
         S_RUN: begin
            if (abort)         w_next = S_IDLE;
            else if (w_finish) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath, hold register and status
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ckdiv     <= '0;
         r_count     <= '0;
         r_emit      <= '0;
         r_hold_data <= '0;
         r_hold_last <= 1'b0;
         r_hold_vld  <= 1'b0;
         r_dout      <= '0;
         r_dstrobe   <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_dstrobe <= w_emit;

         if (w_start_ok) begin
            r_ckdiv <= ckdiv;
            r_count <= count;
         end

         if (w_start_ok) begin
            r_emit <= '0;
         end else if (w_emit) begin
            r_emit <= w_emit_inc;
         end

         if (w_emit) begin
            r_dout <= r_hold_data;
         end

         if (abort || w_finish) begin
            r_hold_vld <= 1'b0;
         end else if (w_hs) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= s_tdata;
            r_hold_last <= s_tlast;
         end else if (w_emit) begin
            r_hold_vld <= 1'b0;
         end

         if (abort || w_start_ok) begin
            r_done <= 1'b0;
         end else if (w_finish) begin
            r_done <= 1'b1;
         end

         if (w_start_ok) begin
            r_underrun <= 1'b0;
         end else if (w_tick_run && !r_hold_vld) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign dout     = r_dout;
   assign dstrobe  = r_dstrobe;
   assign busy     = w_active;
   assign done     = r_done;
   assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_player
//  Description : Directed self-checking bench for pattern_player. Inputs are
//                changed and outputs observed on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pattern_player;

   logic        clk;
   logic        reset;
   logic [4:0]  ckdiv;
   logic        start;
   logic        abort;
   logic [23:0] count;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [31:0] dout;
   logic        dstrobe;
   logic        busy;
   logic        done;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   // stream source model
   logic [31:0] src_data [16];
   logic        src_last [16];
   int          src_n;
   int          src_idx;
   bit          src_on;
   bit          src_gap;

   pattern_player dut (
      .clk      (clk),
      .reset    (reset),
      .ckdiv    (ckdiv),
      .start    (start),
      .abort    (abort),
      .count    (count),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .dout     (dout),
      .dstrobe  (dstrobe),
      .busy     (busy),
      .done     (done),
      .underrun (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic src_set(input int n, input int last_idx,
                          input logic [31:0] base, input logic [31:0] stepv);
      for (int i = 0; i < 16; i++) begin
         src_data[i] = base + 32'(i) * stepv;
         src_last[i] = (i == last_idx);
      end
      src_n   = n;
      src_idx = 0;
      src_on  = 1'b1;
      src_gap = 1'b0;
   endtask

   // Called at a falling edge: present the source word, note whether the
   // coming rising edge completes a handshake, advance to the next falling
   // edge and drop the one-cycle control pulses.
   task automatic cyc();
      bit hs;
      s_tvalid = src_on && !src_gap && (src_idx < src_n);
      s_tdata  = s_tvalid ? src_data[src_idx] : 32'h0;
      s_tlast  = s_tvalid ? src_last[src_idx] : 1'b0;
      #1;
      hs = s_tvalid && s_tready;
      @(negedge clk);
      if (hs) src_idx++;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({dout, dstrobe, s_tready, busy, done, underrun} !== 37'h0) begin
         errors++;
         $display("FAIL reset_state: got dout=%h flags=%b required 0", dout,
                  {dstrobe, s_tready, busy, done, underrun});
      end
   endtask

   task automatic test_steady();
      logic [31:0] exp_w;
      ckdiv = 5'd0; count = 24'd4;
      src_set(4, -1, 32'hA, 32'h1);
      start = 1'b1;
      cyc();
      checks++;
      if ({busy, s_tready, dstrobe} !== 3'b110) begin
         errors++;
         $display("FAIL steady_prime: got busy/tready/strobe=%b required 110",
                  {busy, s_tready, dstrobe});
      end
      cyc();
      for (int i = 0; i < 4; i++) begin
         cyc();
         exp_w = 32'hA + 32'(i);
         checks++;
         if ({dstrobe, dout} !== {1'b1, exp_w}) begin
            errors++;
            $display("FAIL steady_word%0d: got strobe=%b dout=%h required 1 %h",
                     i, dstrobe, dout, exp_w);
         end
      end
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL steady_done: got done/busy=%b required 10", {done, busy});
      end
      cyc();
      checks++;
      if ({done, busy, dstrobe, s_tready} !== 4'b1000) begin
         errors++;
         $display("FAIL steady_idle: got done/busy/strobe/tready=%b required 1000",
                  {done, busy, dstrobe, s_tready});
      end
      src_on = 1'b0;
   endtask

   task automatic test_divider();
      bit          exp_s;
      logic [31:0] exp_w;
      ckdiv = 5'd3; count = 24'd3;
      src_set(3, -1, 32'h1, 32'h1);
      start = 1'b1;
      cyc();
      cyc();
      for (int k = 0; k < 12; k++) begin
         cyc();
         exp_s = ((k % 4) == 0) && (k <= 8);
         checks++;
         if (dstrobe !== exp_s) begin
            errors++;
            $display("FAIL div_strobe_k%0d: got %b required %b", k, dstrobe, exp_s);
         end
         if (exp_s) begin
            exp_w = 32'(k / 4 + 1);
            checks++;
            if (dout !== exp_w) begin
               errors++;
               $display("FAIL div_dout_k%0d: got %h required %h", k, dout, exp_w);
            end
         end
         if (k == 3 || k == 8) begin
            checks++;
            if (done !== (k == 8)) begin
               errors++;
               $display("FAIL div_done_k%0d: got %b required %b", k, done, (k == 8));
            end
         end
      end
      src_on = 1'b0;
   endtask

   task automatic test_tlast();
      logic [31:0] exp_w;
      ckdiv = 5'd0; count = 24'd0;
      src_set(8, 5, 32'h100, 32'h1);
      start = 1'b1;
      cyc();
      cyc();
      for (int i = 0; i < 6; i++) begin
         cyc();
         exp_w = 32'h100 + 32'(i);
         checks++;
         if ({dstrobe, dout} !== {1'b1, exp_w}) begin
            errors++;
            $display("FAIL tlast_word%0d: got strobe=%b dout=%h required 1 %h",
                     i, dstrobe, dout, exp_w);
         end
      end
      checks++;
      if ({done, busy, s_tready} !== 3'b100) begin
         errors++;
         $display("FAIL tlast_done: got done/busy/tready=%b required 100",
                  {done, busy, s_tready});
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if ({s_tready, dstrobe, done} !== 3'b001) begin
            errors++;
            $display("FAIL tlast_after%0d: got tready/strobe/done=%b required 001",
                     i, {s_tready, dstrobe, done});
         end
      end
      src_on = 1'b0;
   endtask

   task automatic test_underrun();
      ckdiv = 5'd0; count = 24'd0;
      src_set(6, 5, 32'h1, 32'h1);
      start = 1'b1;
      cyc();
      cyc();
      cyc();
      checks++;
      if ({dstrobe, underrun, dout} !== {2'b10, 32'h1}) begin
         errors++;
         $display("FAIL ur_w1: got strobe=%b ur=%b dout=%h required 1 0 1",
                  dstrobe, underrun, dout);
      end
      src_gap = 1'b1;
      cyc();
      checks++;
      if ({dstrobe, underrun, dout} !== {2'b10, 32'h2}) begin
         errors++;
         $display("FAIL ur_w2: got strobe=%b ur=%b dout=%h required 1 0 2",
                  dstrobe, underrun, dout);
      end
      cyc();
      checks++;
      if ({dstrobe, underrun, dout} !== {2'b01, 32'h2}) begin
         errors++;
         $display("FAIL ur_gap1: got strobe=%b ur=%b dout=%h required 0 1 2",
                  dstrobe, underrun, dout);
      end
      src_gap = 1'b0;
      cyc();
      checks++;
      if ({dstrobe, underrun, dout, busy} !== {2'b01, 32'h2, 1'b1}) begin
         errors++;
         $display("FAIL ur_gap2: got strobe=%b ur=%b dout=%h busy=%b required 0 1 2 1",
                  dstrobe, underrun, dout, busy);
      end
      for (int w = 3; w <= 6; w++) begin
         cyc();
         checks++;
         if ({dstrobe, underrun, dout} !== {2'b11, 32'(w)}) begin
            errors++;
            $display("FAIL ur_tail%0d: got strobe=%b ur=%b dout=%h required 1 1 %h",
                     w, dstrobe, underrun, dout, 32'(w));
         end
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL ur_done: got %b required 1", done);
      end
      cyc();
      src_on = 1'b0;
      start  = 1'b1;
      cyc();
      checks++;
      if ({busy, underrun, done} !== 3'b100) begin
         errors++;
         $display("FAIL ur_restart_clear: got busy/ur/done=%b required 100",
                  {busy, underrun, done});
      end
      abort = 1'b1;
      cyc();
   endtask

   task automatic test_abort();
      ckdiv = 5'd0; count = 24'd0;
      src_set(8, -1, 32'h11, 32'h11);
      start = 1'b1;
      cyc();
      cyc();
      cyc();
      cyc();
      checks++;
      if (dout !== 32'h22) begin
         errors++;
         $display("FAIL abort_pre: got dout=%h required 22", dout);
      end
      abort = 1'b1;
      cyc();
      checks++;
      if ({busy, done, dstrobe, s_tready, dout} !== {4'b0000, 32'h22}) begin
         errors++;
         $display("FAIL abort_idle: got busy/done/strobe/tready=%b dout=%h required 0000 22",
                  {busy, done, dstrobe, s_tready}, dout);
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if ({s_tready, dstrobe, dout} !== {2'b00, 32'h22}) begin
            errors++;
            $display("FAIL abort_quiet%0d: got tready/strobe=%b dout=%h required 00 22",
                     i, {s_tready, dstrobe}, dout);
         end
      end
      start = 1'b1;
      abort = 1'b1;
      cyc();
      cyc();
      checks++;
      if ({busy, s_tready, done} !== 3'b000) begin
         errors++;
         $display("FAIL start_abort_same: got busy/tready/done=%b required 000",
                  {busy, s_tready, done});
      end
      src_on = 1'b0;
   endtask

   task automatic test_busy_start_and_reset();
      ckdiv = 5'd0; count = 24'd5;
      src_set(8, -1, 32'h1, 32'h1);
      start = 1'b1;
      cyc();
      cyc();
      cyc();
      cyc();
      // second start while running, with a different count, must be ignored
      start = 1'b1;
      count = 24'd2;
      cyc();
      cyc();
      checks++;
      if ({done, dout} !== {1'b0, 32'h4}) begin
         errors++;
         $display("FAIL busy_start_w4: got done=%b dout=%h required 0 4", done, dout);
      end
      cyc();
      checks++;
      if ({done, dout} !== {1'b1, 32'h5}) begin
         errors++;
         $display("FAIL busy_start_w5: got done=%b dout=%h required 1 5", done, dout);
      end
      cyc();
      ckdiv = 5'd0; count = 24'd0;
      src_set(8, -1, 32'h21, 32'h1);
      start = 1'b1;
      cyc();
      cyc();
      cyc();
      cyc();
      checks++;
      if ({busy, dout} !== {1'b1, 32'h22}) begin
         errors++;
         $display("FAIL rst_pre: got busy=%b dout=%h required 1 22", busy, dout);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({dout, dstrobe, s_tready, busy, done, underrun} !== 37'h0) begin
         errors++;
         $display("FAIL rst_async: got dout=%h flags=%b required 0", dout,
                  {dstrobe, s_tready, busy, done, underrun});
      end
      @(negedge clk);
      reset  = 1'b0;
      src_on = 1'b0;
      cyc();
      checks++;
      if ({busy, dstrobe, dout} !== {2'b00, 32'h0}) begin
         errors++;
         $display("FAIL rst_release: got busy/strobe=%b dout=%h required 00 0",
                  {busy, dstrobe}, dout);
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      ckdiv    = 5'd0;
      count    = 24'd0;
      s_tdata  = 32'h0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      src_n    = 0;
      src_idx  = 0;
      src_on   = 1'b0;
      src_gap  = 1'b0;
      @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_steady();
      test_divider();
      test_tlast();
      test_underrun();
      test_abort();
      test_busy_start_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Playback counterpart of the logic-capture path: consumes an AXI-Stream of sample words and drives them onto a parallel digital output bus at a programmable divided rate.
- Turns the analyzer into a pattern generator.
- Sits downstream of an AXI-Stream FIFO (stream slave side) and is controlled by the AXI-MM register block: start, abort, ckdiv, count in; busy, done, underrun out.

Parameters:
- size, 32, width of sample word and output bus.
- max_div, 32, maximum clock divide ratio; DIV_W = $clog2(max_div).
- saddr_w, 24, width of the sample-count register and emitted-sample counter.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- ckdiv  input  DIV_W  divide setting; output period = ckdiv+1 clk cycles; sampled at start.
- start  input  1  one-cycle pulse; begins playback from IDLE.
- abort  input  1  one-cycle pulse; stops playback immediately.
- count  input  saddr_w  samples to emit; 0 = run until tlast; sampled at start.
- s_tdata  input  size  stream sample word.
- s_tvalid  input  1  stream valid.
- s_tlast  input  1  marks final word of the pattern.
- s_tready  output  1  stream ready.
- dout  output  size  registered pattern output.
- dstrobe  output  1  one-cycle pulse in the cycle dout takes a new value.
- busy  output  1  high in PRIME or RUN.
- done  output  1  level; set on normal completion, cleared by start or abort.
- underrun  output  1  sticky; set when a tick finds no word held, cleared by start.

Behaviour:
- Reset values: dout=0, dstrobe=0, s_tready=0, busy=0, done=0, underrun=0, state=IDLE, hold empty, counters 0.
- States:
  - IDLE --start--> PRIME.
  - PRIME --hold register filled--> RUN.
  - RUN --last word emitted--> DONE.
  - DONE --next cycle--> IDLE.
  - Any state --abort--> IDLE on the next cycle.
- start is ignored unless the state is IDLE. If start and abort arrive in the same cycle, abort wins: remain IDLE, nothing latched.
- On start:
  - latch ckdiv and count;
  - clear the emitted counter, done and underrun.
- One-entry hold register (data plus last flag):
  - s_tready = (PRIME or RUN) and (hold empty or hold consumed this cycle).
  - A handshake (s_tvalid and s_tready) loads the hold register; same-cycle consume and refill is allowed.
- Divider:
  - div_cnt is preset to the latched ckdiv on entering RUN, so the first tick occurs in the first RUN cycle.
  - tick when div_cnt == latched ckdiv, then div_cnt <= 0; otherwise div_cnt increments.
  - ckdiv=0 gives a tick every cycle.
- On tick with hold valid:
  - dout <= hold data; dstrobe=1 for that cycle; hold emptied; emitted counter increments.
  - If the hold word's last flag is set, or (count != 0 and emitted+1 == count), go to DONE and set done in the same edge.
- On tick with hold empty:
  - set underrun; dout holds its value; dstrobe=0; emitted counter unchanged; remain in RUN.
- Latency: a word accepted in PRIME appears on dout 1 clk after entering RUN. In steady state (ckdiv=0, stream always valid), one word per cycle with no bubbles.
- count == 0 and no tlast: playback runs until abort; the emitted counter wraps at 2^saddr_w silently.
- Nonzero count and tlast seen first: stop at tlast, with done=1.
- Abort:
  - clears hold and busy; done is not set.
  - dout keeps its last value.
  - Stream words not yet accepted are left in the upstream FIFO; software resets the FIFO.
- Reset mid-operation returns all outputs to their reset values asynchronously.
- In DONE, s_tready=0.

Decomposition:
- Package logicap_pkg holds:
  - state enum {IDLE, PRIME, RUN, DONE};
  - DIV_W derivation;
  - count width constant shared with capture (saddr_w).
- Sub-module clkdiv_tick holds the divider counter.
  - Inputs: clk, reset, clr, preset, div.
  - Output: tick.
  - Reusable by the capture-side sample-rate divider.

Test Plan:
- ckdiv=0, count=4, stream 0xA,0xB,0xC,0xD always valid -> dout steps A,B,C,D on 4 consecutive cycles, 4 dstrobes, done=1 after D, busy=0 next cycle.
- ckdiv=3, count=3, words 1,2,3 -> dstrobe exactly every 4 clks, 3 pulses, then done=1.
- count=0, 6 words with tlast on the 6th -> 6 strobes, done=1, s_tready=0 afterwards with further words pending.
- ckdiv=0, s_tvalid dropped for 2 cycles mid-run -> underrun=1 (sticky), dout held, no strobes in the gap, remaining words emitted; next start clears underrun.
- abort during RUN after 2 of 8 words -> IDLE next cycle, busy=0, done=0, dout=word 2, no further s_tready; start+abort in the same cycle -> stays IDLE.
- Assert reset during RUN -> dout=0, all status 0 immediately; start ignored while busy (second start does not reset the emitted count).
